see_hardened_seq: RTL and testbench

//  Parametrised successor to the SEE-hardened step FSM. A modulo-N up/down step sequencer.
//  Its state register is stored as a Hamming SEC-DED codeword and is scrubbed every clock.

---
 rtl/see_pkg.sv | 85 ++++++++
 rtl/see_secded_dec.sv | 38 +++
 rtl/see_hardened_seq.sv | 121 ++++++++++++
 tb/tb_see_hardened_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/see_pkg.sv
// Shared SEC-DED helpers for the radiation-hardened blocks: Hamming code with an
// overall parity bit at codeword bit 0 and check bits at power-of-two positions.
package see_pkg;

  // Widest codeword the helpers handle; callers cast results down to their width.
  localparam int MAX_CW = 32;

  typedef enum logic [1:0] {
    NONE,
    SEC,
    DED
  } err_t;

  function automatic int secded_r(input int k);
    int r;
    r = 0;
    for (int i = 1; i < 8; i++) begin
      if (r == 0 && (1 << i) >= k + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic logic secded_is_check_pos(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic logic [MAX_CW-1:0] secded_encode(input int k, input logic [MAX_CW-1:0] data);
    logic [MAX_CW-1:0] cw;
    logic              p;
    int                r;
    int                n;
    int                di;
    r  = secded_r(k);
    n  = k + r;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && !secded_is_check_pos(pos)) begin
        cw[pos] = data[di];
        di++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      if (j < r) begin
        p = 1'b0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
          if (pos <= n && pos[j]) p = p ^ cw[pos];
        end
        cw[(1 << j)] = p;
      end
    end
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n) cw[0] = cw[0] ^ cw[pos];
    end
    return cw;
  endfunction

  function automatic logic [7:0] secded_syndrome(input int k, input logic [MAX_CW-1:0] cw);
    logic [7:0] s;
    int         n;
    n = k + secded_r(k);
    s = '0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && cw[pos]) s = s ^ 8'(pos);
    end
    return s;
  endfunction

  function automatic logic [MAX_CW-1:0] secded_extract(input int k, input logic [MAX_CW-1:0] cw);
    logic [MAX_CW-1:0] data;
    int                n;
    int                di;
    n    = k + secded_r(k);
    data = '0;
    di   = 0;
    for (int pos = 1; pos < MAX_CW; pos++) begin
      if (pos <= n && !secded_is_check_pos(pos)) begin
        data[di] = cw[pos];
        di++;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/see_secded_dec.sv
// Combinational SEC-DED decoder: corrects one flipped bit (data, check or parity)
// and flags anything else it can see as uncorrectable.
module see_secded_dec
  import see_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CODE_W = DATA_W + secded_r(DATA_W) + 1
) (
  input  logic [CODE_W-1:0] cw,
  output logic [DATA_W-1:0] data,
  output err_t              err
);

  logic [7:0]        syn;
  logic [CODE_W-1:0] fixed;
  logic              hit;

  always_comb begin
    syn   = secded_syndrome(DATA_W, MAX_CW'(cw));
    fixed = cw;
    hit   = 1'b0;
    // Syndrome 0 with a parity mismatch means the overall parity bit itself flipped.
    for (int i = 0; i < CODE_W; i++) begin
      if (int'(syn) == i) begin
        fixed[i] = ~fixed[i];
        hit      = 1'b1;
      end
    end
    err = NONE;
    if (^cw) begin
      err = hit ? SEC : DED;
    end else if (syn != '0) begin
      err = DED;
    end
    data = DATA_W'(secded_extract(DATA_W, MAX_CW'(fixed)));
  end

endmodule

// File: rtl/see_hardened_seq.sv
// Modulo-N up/down step sequencer whose state lives only in a SEC-DED codeword
// that is re-encoded (scrubbed) on every clock.
module see_hardened_seq
  import see_pkg::*;
#(
  parameter int N_STATES   = 10,
  parameter int ERR_CNT_W  = 8,
  parameter int SAFE_STATE = 0,
  localparam int STATE_W   = $clog2(N_STATES),
  localparam int CODE_W    = STATE_W + secded_r(STATE_W) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 dir,
  input  logic                 inj_valid,
  input  logic [CODE_W-1:0]    inj_mask,
  output logic [STATE_W-1:0]   state,
  output logic                 wrap,
  output logic                 sec,
  output logic                 ded,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] sec_cnt,
  output logic [ERR_CNT_W-1:0] ded_cnt
);

  localparam logic [STATE_W-1:0]   LAST     = STATE_W'(N_STATES - 1);
  localparam logic [STATE_W-1:0]   SAFE     = STATE_W'(SAFE_STATE);
  localparam logic [STATE_W:0]     N_EXT    = (STATE_W + 1)'(N_STATES);
  localparam logic [CODE_W-1:0]    RESET_CW = CODE_W'(secded_encode(STATE_W, '0));
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  logic [CODE_W-1:0]    cw_q, cw_d;
  logic                 wrap_q, wrap_d;
  logic                 sec_q, sec_d;
  logic                 ded_q, ded_d;
  logic                 fault_q, fault_d;
  logic [ERR_CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [ERR_CNT_W-1:0] ded_cnt_q, ded_cnt_d;
  logic [STATE_W-1:0]   s_c;
  logic [STATE_W-1:0]   ns;
  err_t                 dec_err;
  logic                 err_sgl;
  logic                 err_dbl;

  see_secded_dec #(
    .DATA_W (STATE_W),
    .CODE_W (CODE_W)
  ) u_dec (
    .cw   (cw_q),
    .data (s_c),
    .err  (dec_err)
  );

  always_comb begin
    // A cleanly decoded but out-of-range state is as untrustworthy as a double upset.
    err_dbl = (dec_err == DED) || ({1'b0, s_c} >= N_EXT);
    err_sgl = (dec_err == SEC) && !err_dbl;

    ns     = s_c;
    wrap_d = 1'b0;
    if (err_dbl) begin
      ns = SAFE;
    end else if (step) begin
      if (dir) begin
        if (s_c == LAST) begin
          ns     = '0;
          wrap_d = 1'b1;
        end else begin
          ns = s_c + 1'b1;
        end
      end else begin
        if (s_c == '0) begin
          ns     = LAST;
          wrap_d = 1'b1;
        end else begin
          ns = s_c - 1'b1;
        end
      end
    end

    cw_d    = CODE_W'(secded_encode(STATE_W, MAX_CW'(ns))) ^ (inj_valid ? inj_mask : '0);
    sec_d   = err_sgl;
    ded_d   = err_dbl;
    fault_d = fault_q | err_dbl;

    sec_cnt_d = sec_cnt_q;
    if (err_sgl && sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + 1'b1;
    ded_cnt_d = ded_cnt_q;
    if (err_dbl && ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cw_q      <= RESET_CW;
      wrap_q    <= 1'b0;
      sec_q     <= 1'b0;
      ded_q     <= 1'b0;
      fault_q   <= 1'b0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      cw_q      <= cw_d;
      wrap_q    <= wrap_d;
      sec_q     <= sec_d;
      ded_q     <= ded_d;
      fault_q   <= fault_d;
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign state   = s_c;
  assign wrap    = wrap_q;
  assign sec     = sec_q;
  assign ded     = ded_q;
  assign fault   = fault_q;
  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;

endmodule

// File: tb/tb_see_hardened_seq.sv
// Directed bench for see_hardened_seq: stepping, wrap, SEC scrub, DED safe state,
// step on a corrected cycle, counter saturation and reset priority.
module tb_see_hardened_seq;

  logic       clk;
  logic       reset, step, dir, inj_valid;
  logic [7:0] inj_mask;
  logic [3:0] state;
  logic       wrap, sec, ded, fault;
  logic [7:0] sec_cnt, ded_cnt;

  logic       s_reset, s_step, s_dir, s_inj_valid;
  logic [7:0] s_inj_mask;
  logic [3:0] s_state;
  logic       s_wrap, s_sec, s_ded, s_fault;
  logic [1:0] s_sec_cnt, s_ded_cnt;

  logic [3:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  int         wraps;

  see_hardened_seq #(.N_STATES(10), .ERR_CNT_W(8), .SAFE_STATE(0)) dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir),
    .inj_valid(inj_valid), .inj_mask(inj_mask),
    .state(state), .wrap(wrap), .sec(sec), .ded(ded), .fault(fault),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  see_hardened_seq #(.N_STATES(10), .ERR_CNT_W(2), .SAFE_STATE(0)) dut_sat (
    .clk(clk), .reset(s_reset), .step(s_step), .dir(s_dir),
    .inj_valid(s_inj_valid), .inj_mask(s_inj_mask),
    .state(s_state), .wrap(s_wrap), .sec(s_sec), .ded(s_ded), .fault(s_fault),
    .sec_cnt(s_sec_cnt), .ded_cnt(s_ded_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic d);
    step = 1'b1;
    dir  = d;
    tick();
    step = 1'b0;
  endtask

  task automatic do_inject(input logic [7:0] m);
    inj_valid = 1'b1;
    inj_mask  = m;
    tick();
    inj_valid = 1'b0;
    inj_mask  = '0;
  endtask

  task automatic sat_step_up();
    s_step = 1'b1;
    s_dir  = 1'b1;
    tick();
    s_step = 1'b0;
  endtask

  task automatic sat_inject(input logic [7:0] m);
    s_inj_valid = 1'b1;
    s_inj_mask  = m;
    tick();
    s_inj_valid = 1'b0;
    s_inj_mask  = '0;
  endtask

  initial begin
    logic [7:0] sat_masks [5];
    sat_masks = '{8'h01, 8'h02, 8'h20, 8'h40, 8'h80};
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; step = 1'b0; dir = 1'b1; inj_valid = 1'b0; inj_mask = '0;
    s_reset = 1'b1; s_step = 1'b0; s_dir = 1'b1; s_inj_valid = 1'b0; s_inj_mask = '0;

    // 1. reset
    tick();
    tick();
    reset   = 1'b0;
    s_reset = 1'b0;
    check_eq("rst_state", state, 0);
    check_eq("rst_cw", dut.cw_q, 8'h00);
    check_eq("rst_flags", {wrap, sec, ded, fault}, 4'b0000);
    check_eq("rst_sec_cnt", sec_cnt, 0);
    check_eq("rst_ded_cnt", ded_cnt, 0);
    tick();
    check_eq("idle_state", state, 0);

    // 2. count up 12, then down 3
    for (int i = 1; i <= 12; i++) exp_q.push_back(4'(i % 10));
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      do_step(1'b1);
      if (wrap) wraps++;
      check_eq("up_state", state, exp_q.pop_front());
      check_eq("up_wrap", wrap, (i == 9) ? 1 : 0);
      repeat (63) tick();
    end
    check_eq("up_wrap_count", wraps, 1);
    exp_q = '{4'd1, 4'd0, 4'd9};
    for (int i = 0; i < 3; i++) begin
      do_step(1'b0);
      check_eq("dn_state", state, exp_q.pop_front());
      check_eq("dn_wrap", wrap, (i == 2) ? 1 : 0);
      tick();
      check_eq("dn_wrap_clear", wrap, 0);
    end
    repeat (4) do_step(1'b1);
    check_eq("at3_state", state, 3);
    check_eq("at3_cw", dut.cw_q, 8'h3C);

    // 3. single-bit upset on check bit p1 while idle
    do_inject(8'h04);
    check_eq("sec_upset_state", state, 3);
    check_eq("sec_upset_cw", dut.cw_q, 8'h38);
    check_eq("sec_upset_pulse", sec, 0);
    tick();
    check_eq("sec_fix_state", state, 3);
    check_eq("sec_fix_pulse", sec, 1);
    check_eq("sec_fix_cnt", sec_cnt, 1);
    check_eq("sec_fix_cw", dut.cw_q, 8'h3C);
    check_eq("sec_fix_ded", ded, 0);
    tick();
    check_eq("sec_pulse_end", sec, 0);
    check_eq("sec_after_state", state, 3);

    // 4. double-bit upset at state 5
    do_step(1'b1);
    do_step(1'b1);
    check_eq("at5_cw", dut.cw_q, 8'h5A);
    do_inject(8'h03);
    tick();
    check_eq("ded_state", state, 0);
    check_eq("ded_pulse", ded, 1);
    check_eq("ded_cnt", ded_cnt, 1);
    check_eq("ded_fault", fault, 1);
    check_eq("ded_no_wrap", wrap, 0);
    check_eq("ded_no_sec", sec, 0);
    check_eq("ded_cw", dut.cw_q, 8'h00);
    tick();
    check_eq("ded_pulse_end", ded, 0);
    repeat (100) tick();
    for (int i = 0; i < 10; i++) do_step(1'b1);
    check_eq("fault_sticky", fault, 1);
    check_eq("fault_state", state, 0);
    check_eq("fault_ded_cnt", ded_cnt, 1);

    // 5. upset at state 9, step on the corrected cycle
    do_step(1'b0);
    check_eq("at9_state", state, 9);
    check_eq("at9_cw", dut.cw_q, 8'h99);
    do_inject(8'h10);
    check_eq("at9_upset_state", state, 9);
    do_step(1'b1);
    check_eq("sec_step_state", state, 0);
    check_eq("sec_step_wrap", wrap, 1);
    check_eq("sec_step_sec", sec, 1);
    check_eq("sec_step_ded", ded, 0);
    check_eq("sec_step_cnt", sec_cnt, 2);
    check_eq("sec_step_cw", dut.cw_q, 8'h00);

    // 6. saturating counters and reset priority on the ERR_CNT_W=2 instance
    for (int i = 0; i < 6; i++) sat_step_up();
    check_eq("sat_at6", s_state, 6);
    for (int k = 0; k < 5; k++) begin
      sat_inject(sat_masks[k]);
      check_eq("sat_upset_state", s_state, 6);
      tick();
      check_eq("sat_sec", s_sec, 1);
      check_eq("sat_cnt", s_sec_cnt, (k < 3) ? k + 1 : 3);
    end
    check_eq("sat_ded_cnt", s_ded_cnt, 0);
    s_reset     = 1'b1;
    s_step      = 1'b1;
    s_inj_valid = 1'b1;
    s_inj_mask  = 8'h01;
    tick();
    s_reset     = 1'b0;
    s_step      = 1'b0;
    s_inj_valid = 1'b0;
    s_inj_mask  = '0;
    check_eq("sat_rst_state", s_state, 0);
    check_eq("sat_rst_cw", dut_sat.cw_q, 8'h00);
    check_eq("sat_rst_flags", {s_wrap, s_sec, s_ded, s_fault}, 4'b0000);
    check_eq("sat_rst_cnts", {s_sec_cnt, s_ded_cnt}, 4'b0000);
    tick();
    check_eq("sat_post_rst_sec", s_sec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
